mul_tree_sched: RTL and testbench
=================================

Name: mul_tree_sched

Overview:
- Batches product jobs (2, 3, 4 or 6 bf16 operands each) onto the shared 7-multiplier bf16 product tree.
- Selects the tree mode, packs operand slots and pads unused slots with 1.0 (0x3F80).
- Keeps the tree pipeline advancing while work is in flight.
- Returns tagged results. Sits between the job producer and mul_tree; the only block that drives tree mode/stb.

Parameters:
- STAGE_LAT, 3, latency in cycles of one multiplier stage; tree level latency.
- TAG_W, 4, job tag width.
- BATCH_WAIT, 4, idle cycles in FILL before a partial batch is issued.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  job offered
- in_ready  out  1  job accepted when in_valid&in_ready
- in_cls  in  2  0=2 ops, 1=3 ops, 2=4 ops, 3=6 ops (same code as tree mode)
- in_ops  in  96  operand k at [16k+15:16k]; ops beyond count ignored
- in_tag  in  TAG_W  job tag
- tree_ins  out  128  8 bf16 slots, slot s at [16s+15:16s]
- tree_mode  out  2  tree mode
- tree_stb  out  1  tree pipeline advance
- tree_outs  in  64  tree results, lane i at [16i+15:16i]
- res_valid  out  4  per-lane result valid (one-cycle pulse)
- res_data  out  64  lane i product
- res_tag  out  4*TAG_W  lane i tag

Behaviour:
- Reset (async): state IDLE; all outputs 0 except tree_ins = all slots 0x3F80; tree_mode = 0; in-flight count 0; delay line cleared. In-flight results are discarded.
- Capacity per class: 2→4 lanes, 3→2, 4→2, 6→1. Levels L: 2→1, 3/4→2, 6→3. Latency = STAGE_LAT*L.
- Slot packing:
  - 2-op job at lane j: slots 2j, 2j+1.
  - 3-op lane g: slots 4g..4g+2, slot 4g+3 = 0x3F80.
  - 4-op lane g: slots 4g..4g+3.
  - 6-op: slots 0..5, slots 6,7 = 0x3F80.
  - Unfilled lanes: all their slots 0x3F80.
- FSM states IDLE, FILL, DRAIN, ISSUE:
  - IDLE: in_ready=1. On accept, load lane 0, latch class, clear wait counter. Go to FILL if capacity>1. Otherwise go to DRAIN if mismatch, else ISSUE.
  - FILL: in_ready=1 only when in_cls equals the latched class and lanes are not full. An accept fills the next lane in acceptance order and resets the wait counter; otherwise the wait counter increments. Batch closes when lanes are full, a valid job of a different class is presented, or the wait counter reaches BATCH_WAIT. On close, go to DRAIN if mismatch, else ISSUE.
  - mismatch = in-flight count>0 and tree_mode≠class.
  - DRAIN: in_ready=0; wait until in-flight count = 0, then ISSUE.
  - ISSUE (1 cycle): in_ready=0. tree_ins, tree_mode and tree_stb are registered and valid in this cycle. Push {mode, lane mask, tags} into the delay line; in-flight count +1. Then go to IDLE.
- tree_mode changes only in an ISSUE cycle with in-flight count 0. It holds otherwise.
- tree_stb = 1 in ISSUE and in every cycle with in-flight count>0; 0 otherwise. Non-ISSUE cycles with tree_stb=1 drive all slots 0x3F80 (bubbles).
- Delay line: depth 3*STAGE_LAT+1, shifts every cycle. The entry of age STAGE_LAT*L(mode) pops. In the following cycle (ISSUE cycle t → cycle t+STAGE_LAT*L+1), register tree_outs into res_data, mask into res_valid, tags into res_tag; in-flight count −1.
- Push and pop in the same cycle: count unchanged.
- Minimum issue spacing is 2 cycles.
- Results have no backpressure; res_* is valid only on the pulse cycle.

Test Plan:
1. Four back-to-back 2-op jobs {0x4000,0x4040}, tags 0..3 → one ISSUE with tree_mode=0; 4 cycles later (STAGE_LAT=3) res_valid=4'b1111, all lanes 0x40C0, tags 0,1,2,3.
2. Single 3-op job {0x4000,0x4000,0x4000}, then in_valid low → ISSUE after BATCH_WAIT idle cycles, mode 1, slots 3..7 = 0x3F80; 7 cycles later res_valid=4'b0001, data 0x4100.
3. 6-op job {0x4000×4, 0x3F00×2} → ISSUE directly from IDLE with mode 3; 10 cycles later lane0=0x4080, res_valid=4'b0001; tree_stb high for all 10 cycles.
4. 2-op job tag 5, next cycle 6-op job tag 6 → in_ready=0 for the 6-op job; 2-op batch issues with mode 0, then the 6-op job waits in DRAIN. tree_mode stays 0 until tag 5 result pulses, then the 6-op ISSUE sets mode 3. Results arrive in order 5, 6.
5. Assert rst two cycles after a mode-2 ISSUE → all outputs reset immediately, tree_stb=0; after release no res_valid pulse ever appears for that job.
6. FILL with class-1 job, present class-2 job → in_ready=0 that cycle, class-1 batch issues with one lane; class-2 job accepted in the next IDLE.

Source files
------------

// File: rtl/mul_tree_sched.sv
// mul_tree_sched: batches 2/3/4/6-operand bf16 product jobs onto the shared
// 7-multiplier tree and returns tagged per-lane results after the tree latency.
module mul_tree_sched #(
  parameter int STAGE_LAT  = 3,
  parameter int TAG_W      = 4,
  parameter int BATCH_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_cls,
  input  logic [95:0]        in_ops,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [127:0]       tree_ins,
  output logic [1:0]         tree_mode,
  output logic               tree_stb,
  input  logic [63:0]        tree_outs,
  output logic [3:0]         res_valid,
  output logic [63:0]        res_data,
  output logic [4*TAG_W-1:0] res_tag
);
  localparam int DEPTH = 3*STAGE_LAT+1;
  localparam int A1 = STAGE_LAT-1;
  localparam int A2 = 2*STAGE_LAT-1;
  localparam int A3 = 3*STAGE_LAT-1;
  localparam int WW = $clog2(BATCH_WAIT+1);
  localparam logic [WW-1:0] BW = WW'(BATCH_WAIT);
  localparam logic [15:0] ONE = 16'h3F80;
  localparam logic [127:0] PAD = {8{ONE}};

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, ISSUE} state_t;

  typedef struct packed {
    logic               v;
    logic [1:0]         mode;
    logic [3:0]         mask;
    logic [4*TAG_W-1:0] tags;
  } dl_t;

  function automatic logic [2:0] cap_of(input logic [1:0] c);
    unique case (c)
      2'd0:       cap_of = 3'd4;
      2'd1, 2'd2: cap_of = 3'd2;
      default:    cap_of = 3'd1;
    endcase
  endfunction

  function automatic int nops_of(input logic [1:0] c);
    unique case (c)
      2'd0:    nops_of = 2;
      2'd1:    nops_of = 3;
      2'd2:    nops_of = 4;
      default: nops_of = 6;
    endcase
  endfunction

  state_t             state, ns;
  logic [1:0]         cls, cls_n;
  logic [127:0]       slots, slots_n;
  logic [3:0]         mask, mask_n;
  logic [4*TAG_W-1:0] tags, tags_n;
  logic [2:0]         lane_cnt, lane_n;
  logic [WW-1:0]      wait_cnt, wait_n, wait_inc;
  logic [3:0]         cnt, cnt_n;
  logic               busy, acc, close, push, pop;
  logic [1:0]         lane;
  int                 base;
  dl_t                dl [DEPTH];
  dl_t                dl_c [DEPTH];
  dl_t                pop_e, push_e;

  assign busy     = cnt != 4'd0;
  assign wait_inc = wait_cnt + 1'b1;
  assign push     = state == ISSUE;

  always_comb begin
    ns       = state;
    in_ready = 1'b0;
    acc      = 1'b0;
    close    = 1'b0;
    cls_n    = cls;
    slots_n  = slots;
    mask_n   = mask;
    tags_n   = tags;
    lane_n   = lane_cnt;
    wait_n   = wait_cnt;
    lane     = 2'd0;
    base     = 0;
    unique case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          acc     = 1'b1;
          cls_n   = in_cls;
          slots_n = PAD;
          mask_n  = '0;
          tags_n  = '0;
          lane_n  = '0;
          wait_n  = '0;
          if (cap_of(in_cls) != 3'd1) ns = FILL;
          else if (busy && tree_mode != in_cls) ns = DRAIN;
          else ns = ISSUE;
        end
      end
      FILL: begin
        in_ready = (in_cls == cls) && (lane_cnt < cap_of(cls));
        acc      = in_valid && in_ready;
        wait_n   = acc ? '0 : wait_inc;
        close    = (acc && (lane_cnt + 3'd1 == cap_of(cls)))
                || (in_valid && in_cls != cls)
                || (!acc && wait_inc == BW);
        if (close) ns = (busy && tree_mode != cls) ? DRAIN : ISSUE;
      end
      DRAIN: if (!busy) ns = ISSUE;
      default: ns = IDLE;
    endcase
    // 2-op jobs pair up per lane; 3/4-op jobs take a 4-slot group
    if (acc) begin
      lane = lane_n[1:0];
      mask_n[lane] = 1'b1;
      tags_n[int'(lane)*TAG_W +: TAG_W] = in_tag;
      base = (cls_n == 2'd0) ? 2*int'(lane) : 4*int'(lane);
      for (int k = 0; k < 6; k++)
        if (k < nops_of(cls_n) && base + k < 8)
          slots_n[16*(base+k) +: 16] = in_ops[16*k +: 16];
      lane_n = lane_n + 3'd1;
    end
  end

  always_comb begin
    pop  = 1'b0;
    pop_e = '0;
    dl_c = dl;
    if (dl[A1].v && dl[A1].mode == 2'd0) begin
      pop = 1'b1;
      pop_e = dl[A1];
      dl_c[A1].v = 1'b0;
    end
    if (dl[A2].v && (dl[A2].mode == 2'd1 || dl[A2].mode == 2'd2)) begin
      pop = 1'b1;
      pop_e = dl[A2];
      dl_c[A2].v = 1'b0;
    end
    if (dl[A3].v && dl[A3].mode == 2'd3) begin
      pop = 1'b1;
      pop_e = dl[A3];
      dl_c[A3].v = 1'b0;
    end
    push_e = '0;
    if (push) begin
      push_e.v    = 1'b1;
      push_e.mode = tree_mode;
      push_e.mask = mask;
      push_e.tags = tags;
    end
    cnt_n = cnt + {3'd0, push} - {3'd0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cls       <= '0;
      slots     <= PAD;
      mask      <= '0;
      tags      <= '0;
      lane_cnt  <= '0;
      wait_cnt  <= '0;
      cnt       <= '0;
      tree_ins  <= PAD;
      tree_mode <= '0;
      tree_stb  <= 1'b0;
      res_valid <= '0;
      res_data  <= '0;
      res_tag   <= '0;
      for (int i = 0; i < DEPTH; i++) dl[i] <= '0;
    end else begin
      state    <= ns;
      cls      <= cls_n;
      slots    <= slots_n;
      mask     <= mask_n;
      tags     <= tags_n;
      lane_cnt <= lane_n;
      wait_cnt <= wait_n;
      cnt      <= cnt_n;
      // outputs are registered so they line up with the ISSUE cycle
      tree_ins  <= (ns == ISSUE) ? slots_n : PAD;
      tree_mode <= (ns == ISSUE) ? cls_n : tree_mode;
      tree_stb  <= (ns == ISSUE) || (cnt_n != 4'd0);
      dl[0] <= push_e;
      for (int i = 1; i < DEPTH; i++) dl[i] <= dl_c[i-1];
      res_valid <= pop ? pop_e.mask : 4'd0;
      if (pop) begin
        res_data <= tree_outs;
        res_tag  <= pop_e.tags;
      end
    end
  end
endmodule

// File: tb/tb_mul_tree_sched.sv
// tb_mul_tree_sched: directed table-driven checks of batching, packing,
// mode sequencing and result timing against a scripted tree model.
module tb_mul_tree_sched;
  localparam int SL = 3;
  localparam int TW = 4;
  localparam int BWT = 4;
  localparam logic [127:0] PAD = {8{16'h3F80}};
  localparam logic [63:0] DEAD = {4{16'hDEAD}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_cls = '0;
  logic [95:0]   in_ops = '0;
  logic [TW-1:0] in_tag = '0;
  logic [127:0]  tree_ins;
  logic [1:0]    tree_mode;
  logic          tree_stb;
  logic [63:0]   tree_outs = '0;
  logic [3:0]    res_valid;
  logic [63:0]   res_data;
  logic [4*TW-1:0] res_tag;

  mul_tree_sched #(.STAGE_LAT(SL), .TAG_W(TW), .BATCH_WAIT(BWT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_ops(in_ops), .in_tag(in_tag),
    .tree_ins(tree_ins), .tree_mode(tree_mode), .tree_stb(tree_stb),
    .tree_outs(tree_outs),
    .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nerr = 0;

  // scripted tree: presents queued products exactly in the pop cycle
  typedef struct { int c; int lat; logic [63:0] o; } pend_t;
  pend_t        pend[$];
  logic [63:0]  outs_q[$];
  int           iss_cnt = 0;
  int           iss_cyc[$];
  logic [1:0]   iss_mode[$];
  logic [127:0] iss_ins[$];

  function automatic int lat_of(input logic [1:0] m);
    if (m == 2'd0) return SL;
    if (m == 2'd3) return 3*SL;
    return 2*SL;
  endfunction

  always @(negedge clk) begin : mdl
    pend_t p;
    logic [63:0] o;
    o = DEAD;
    foreach (pend[i]) if (pend[i].c + pend[i].lat == cyc) o = pend[i].o;
    if (tree_stb && tree_ins != PAD) begin
      p.c = cyc;
      p.lat = lat_of(tree_mode);
      p.o = (outs_q.size() > 0) ? outs_q.pop_front() : DEAD;
      pend.push_back(p);
      iss_cyc.push_back(cyc);
      iss_mode.push_back(tree_mode);
      iss_ins.push_back(tree_ins);
      iss_cnt++;
    end
    tree_outs = o;
  end

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic tmo(input string nm);
    ncmp++;
    nerr++;
    $display("FAIL %s: timeout, got no event want event", nm);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [95:0] o,
                      input logic [3:0] t);
    in_valid = 1'b1;
    in_cls = c;
    in_ops = o;
    in_tag = t;
    #1;
    for (int n = 0; n < 40 && !in_ready; n++) step();
    if (!in_ready) tmo("send_accept");
    else begin
      @(posedge clk);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_issue(input int i0, output bit ok);
    for (int n = 0; n < 30 && iss_cnt <= i0; n++) step();
    ok = iss_cnt > i0;
    if (!ok) tmo("issue_wait");
  endtask

  task automatic wait_res(input string nm, output bit ok);
    for (int n = 0; n < 40 && res_valid == 4'd0; n++) step();
    ok = res_valid != 4'd0;
    if (!ok) tmo(nm);
  endtask

  typedef struct {
    logic [1:0]   cls;
    int           n;
    logic [95:0]  ops;
    logic [3:0]   tag0;
    logic [127:0] ins;
    logic [1:0]   mode;
    int           lat;
    logic [63:0]  outs;
    logic [3:0]   vld;
    logic [15:0]  tags;
  } row_t;

  row_t rows[5];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    bit ok;
    int i0, ic, p1;
    logic bad;

    rows[0] = '{2'd0, 4, 96'h1234_1234_1234_1234_4040_4000, 4'h0,
      128'h4040_4000_4040_4000_4040_4000_4040_4000, 2'd0, 3,
      {4{16'h40C0}}, 4'b1111, 16'h3210};
    rows[1] = '{2'd1, 1, 96'h1234_1234_1234_4000_4000_4000, 4'h7,
      128'h3F80_3F80_3F80_3F80_3F80_4000_4000_4000, 2'd1, 6,
      64'h3F80_3F80_3F80_4100, 4'b0001, 16'h0007};
    rows[2] = '{2'd3, 1, 96'h3F00_3F00_4000_4000_4000_4000, 4'h9,
      128'h3F80_3F80_3F00_3F00_4000_4000_4000_4000, 2'd3, 9,
      64'h3F80_3F80_3F80_4080, 4'b0001, 16'h0009};
    rows[3] = '{2'd2, 2, 96'h1234_1234_3F80_4000_4000_4000, 4'hA,
      128'h3F80_4000_4000_4000_3F80_4000_4000_4000, 2'd2, 6,
      64'h3F80_3F80_4100_4100, 4'b0011, 16'h00BA};
    rows[4] = '{2'd0, 2, 96'h1234_1234_1234_1234_4000_3F80, 4'hC,
      128'h3F80_3F80_3F80_3F80_4000_3F80_4000_3F80, 2'd0, 3,
      64'h3F80_3F80_4000_4000, 4'b0011, 16'h00DC};

    step();
    chk("rst_ins", tree_ins, PAD);
    chk("rst_mode", tree_mode, 0);
    chk("rst_stb", tree_stb, 0);
    chk("rst_rvalid", res_valid, 0);
    chk("rst_rdata", res_data, 0);
    chk("rst_rtag", res_tag, 0);
    chk("rst_ready", in_ready, 0);
    step();
    rst = 1'b0;
    step();
    step();

    for (int r = 0; r < 5; r++) begin
      outs_q.push_back(rows[r].outs);
      i0 = iss_cnt;
      for (int j = 0; j < rows[r].n; j++)
        send(rows[r].cls, rows[r].ops, rows[r].tag0 + 4'(j));
      wait_issue(i0, ok);
      if (ok) begin
        ic = iss_cyc[i0];
        chk($sformatf("r%0d_ins", r), iss_ins[i0], rows[r].ins);
        chk($sformatf("r%0d_mode", r), iss_mode[i0], rows[r].mode);
        bad = 1'b0;
        for (int n = 0; n < 40 && res_valid == 4'd0; n++) begin
          if (!tree_stb) bad = 1'b1;
          if (cyc == ic + 1 && tree_ins !== PAD) bad = 1'b1;
          step();
        end
        if (res_valid == 4'd0) tmo($sformatf("r%0d_res", r));
        else begin
          chk($sformatf("r%0d_lat", r), cyc - ic, rows[r].lat + 1);
          chk($sformatf("r%0d_vld", r), res_valid, rows[r].vld);
          chk($sformatf("r%0d_data", r), res_data, rows[r].outs);
          chk($sformatf("r%0d_tags", r), res_tag, rows[r].tags);
          chk($sformatf("r%0d_stb_run", r), bad, 0);
          chk($sformatf("r%0d_stb_off", r), tree_stb, 0);
          step();
          chk($sformatf("r%0d_pulse", r), res_valid, 0);
        end
      end
      step();
      step();
    end

    // class change while the tree is busy: drain before the mode switch
    outs_q.push_back(64'h3F80_3F80_3F80_4080);
    outs_q.push_back(64'h3F80_3F80_3F80_4100);
    i0 = iss_cnt;
    in_valid = 1'b1;
    in_cls = 2'd0;
    in_ops = 96'h1234_1234_1234_1234_4000_4000;
    in_tag = 4'd5;
    #1;
    chk("t4_rdy_a", in_ready, 1);
    @(posedge clk);
    step();
    in_cls = 2'd3;
    in_ops = 96'h3F80_3F80_3F80_4000_4000_4000;
    in_tag = 4'd6;
    #1;
    chk("t4_rdy_b", in_ready, 0);
    for (int n = 0; n < 40 && !in_ready; n++) step();
    if (!in_ready) tmo("t4_accept");
    else begin
      @(posedge clk);
      step();
    end
    in_valid = 1'b0;
    wait_res("t4_res1", ok);
    if (ok) begin
      p1 = cyc;
      chk("t4_tag1", res_tag[3:0], 5);
      chk("t4_vld1", res_valid, 4'b0001);
      chk("t4_data1", res_data[15:0], 16'h4080);
      chk("t4_mode_hold", tree_mode, 0);
      chk("t4_no_early", iss_cnt, i0 + 1);
      step();
      wait_res("t4_res2", ok);
      if (ok && iss_cnt >= i0 + 2) begin
        chk("t4_mode_a", iss_mode[i0], 0);
        chk("t4_mode_b", iss_mode[i0+1], 3);
        chk("t4_after", iss_cyc[i0+1] > p1, 1);
        chk("t4_tag2", res_tag[3:0], 6);
        chk("t4_data2", res_data[15:0], 16'h4100);
      end else if (ok) tmo("t4_issue2");
    end
    step();
    step();

    // class-1 batch closed by a class-2 job; class-2 taken in next IDLE
    outs_q.push_back(64'h3F80_3F80_3F80_4080);
    outs_q.push_back(64'h3F80_3F80_3F80_4180);
    i0 = iss_cnt;
    send(2'd1, 96'h1234_1234_1234_3F80_4000_4000, 4'd1);
    in_valid = 1'b1;
    in_cls = 2'd2;
    in_ops = 96'h1234_1234_4000_4000_4000_4000;
    in_tag = 4'd2;
    #1;
    chk("t6_rdy_b", in_ready, 0);
    for (int n = 0; n < 40 && !in_ready; n++) step();
    if (!in_ready || iss_cnt <= i0) tmo("t6_accept");
    else begin
      chk("t6_acc_idle", cyc, iss_cyc[i0] + 1);
      chk("t6_ins_a", iss_ins[i0],
          128'h3F80_3F80_3F80_3F80_3F80_3F80_4000_4000);
      @(posedge clk);
      step();
    end
    in_valid = 1'b0;
    wait_res("t6_res1", ok);
    if (ok) begin
      chk("t6_vld1", res_valid, 4'b0001);
      chk("t6_tag1", res_tag, 16'h0001);
      chk("t6_data1", res_data, 64'h3F80_3F80_3F80_4080);
      step();
      wait_res("t6_res2", ok);
      if (ok && iss_cnt >= i0 + 2) begin
        chk("t6_mode_b", iss_mode[i0+1], 2);
        chk("t6_ins_b", iss_ins[i0+1],
            128'h3F80_3F80_3F80_3F80_4000_4000_4000_4000);
        chk("t6_tag2", res_tag, 16'h0002);
        chk("t6_data2", res_data, 64'h3F80_3F80_3F80_4180);
      end else if (ok) tmo("t6_issue2");
    end
    step();
    step();

    // reset with a mode-2 job in flight: its result must never appear
    outs_q.push_back(64'h3F80_3F80_3F80_4100);
    i0 = iss_cnt;
    send(2'd2, 96'h1234_1234_3F80_4000_4000_4000, 4'd3);
    wait_issue(i0, ok);
    if (ok) chk("t5_mode", iss_mode[i0], 2);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t5_stb", tree_stb, 0);
    chk("t5_mode_rst", tree_mode, 0);
    chk("t5_ins", tree_ins, PAD);
    chk("t5_rvalid", res_valid, 0);
    chk("t5_ready", in_ready, 0);
    step();
    rst = 1'b0;
    pend.delete();
    outs_q.delete();
    bad = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (res_valid != 4'd0 || tree_stb) bad = 1'b1;
      step();
    end
    chk("t5_no_res", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
